// File: rtl/calc_pkg.sv
// Shared definitions for the calculator divide unit: state encodings and default sizing.
package calc_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CW    = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ITER = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Control-unit <-> divider bundle. The control unit is the master (drives go and the operands).
// Handshake: go is sampled only while busy=0; completion is a one-cycle done pulse with results already registered.
interface seq_divider_if #(
  parameter int WIDTH = calc_pkg::DEF_WIDTH
);

  logic             go;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             div_by_zero;
  logic             busy;
  logic [1:0]       CS;

  modport master (
    output go, dividend, divisor,
    input  quotient, remainder, done, div_by_zero, busy, CS
  );

  modport slave (
    input  go, dividend, divisor,
    output quotient, remainder, done, div_by_zero, busy, CS
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step on the packed {R,Q} working value.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH:0] rq_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [2*WIDTH:0] rq_o
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_sub;

  // R stays below D, so the bit shifted out of the top is always zero.
  always_comb begin
    shifted = rq_i << 1;
    r_sh    = shifted[2*WIDTH:WIDTH];
    r_sub   = r_sh - {1'b0, d_i};
    rq_o    = shifted;
    if (r_sh >= {1'b0, d_i}) begin
      rq_o[2*WIDTH:WIDTH] = r_sub;
      rq_o[0]             = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, results held until the next completion.
module seq_divider
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             done_q;
  logic             dbz_q;
  logic [2*WIDTH:0] rq_d;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rq_i (({r_q, q_q})),
    .d_i  (d_q),
    .rq_o (rq_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.go) begin
            if (bus.divisor != '0) begin
              d_q     <= bus.divisor;
              q_q     <= bus.dividend;
              r_q     <= '0;
              cnt_q   <= CW'(WIDTH);
              dbz_q   <= 1'b0;
              state_q <= S_ITER;
            end else begin
              quo_q   <= '1;
              rem_q   <= bus.dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_ITER: begin
          r_q   <= rq_d[2*WIDTH:WIDTH];
          q_q   <= rq_d[WIDTH-1:0];
          cnt_q <= cnt_q - CW'(1);
          // Outputs are loaded straight from the final step so no partial result is ever visible.
          if (cnt_q == CW'(1)) begin
            quo_q   <= rq_d[WIDTH-1:0];
            rem_q   <= rq_d[2*WIDTH-1:WIDTH];
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.CS          = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: results predicted at issue time, checked on each done pulse.
module tb_seq_divider;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W), .CW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Entry layout: {quotient, remainder, div_by_zero}
  logic [2*W:0]   exp_q[$];
  logic [W-1:0]   last_q    = '0;
  logic [W-1:0]   last_r    = '0;
  logic           last_done = 1'b0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {{W{1'b1}}, a, 1'b1};
    return {W'(a / b), W'(a % b), 1'b0};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    logic [2*W:0] e;
    if (rst && bus.done) begin
      check_eq("done_single", 16'(last_done), 16'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 16'(bus.done), 16'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("quotient", 16'(bus.quotient), 16'(e[2*W:W+1]));
        check_eq("remainder", 16'(bus.remainder), 16'(e[W:1]));
        check_eq("div_by_zero", 16'(bus.div_by_zero), 16'(e[0]));
        last_q = e[2*W:W+1];
        last_r = e[W:1];
      end
    end
    last_done = bus.done;
  end

  task automatic drive_go(input logic [W-1:0] a, input logic [W-1:0] b, input bit clr_after);
    @(posedge clk); #1;
    bus.go       = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    exp_q.push_back(model(a, b));
    @(posedge clk); #1;
    bus.go       = 1'b0;
    bus.dividend = clr_after ? '0 : W'($urandom);
    bus.divisor  = clr_after ? '0 : W'($urandom);
  endtask

  task automatic wait_done(input bit dbz_op);
    int n = 0;
    bit seen = 0;
    int exp_lat = dbz_op ? 1 : W + 1;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        seen = 1;
      end else begin
        check_eq("cs_iter", 16'(bus.CS), 16'd1);
        check_eq("busy_iter", 16'(bus.busy), 16'd1);
        check_eq("quo_no_partial", 16'(bus.quotient), 16'(last_q));
        check_eq("rem_no_partial", 16'(bus.remainder), 16'(last_r));
        if (n == 1) check_eq("dbz_clear_on_accept", 16'(bus.div_by_zero), 16'd0);
      end
    end
    check_eq("latency", 16'(n), 16'(exp_lat));
    check_eq("cs_done", 16'(bus.CS), 16'd2);
    @(negedge clk);
    check_eq("cs_idle", 16'(bus.CS), 16'd0);
    check_eq("busy_idle", 16'(bus.busy), 16'd0);
    check_eq("done_low", 16'(bus.done), 16'd0);
  endtask

  initial begin
    int prev_cs, starts, t, first_t, second_t;
    logic [W-1:0] ra, rb;

    bus.go = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cs", 16'(bus.CS), 16'd0);
    check_eq("rst_busy", 16'(bus.busy), 16'd0);
    check_eq("rst_done", 16'(bus.done), 16'd0);
    check_eq("rst_quo", 16'(bus.quotient), 16'd0);
    check_eq("rst_rem", 16'(bus.remainder), 16'd0);
    check_eq("rst_dbz", 16'(bus.div_by_zero), 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    drive_go(4'd13, 4'd4, 1'b0); wait_done(1'b0);
    drive_go(4'd7, 4'd0, 1'b0);  wait_done(1'b1);
    repeat (2) @(negedge clk);
    check_eq("dbz_hold", 16'(bus.div_by_zero), 16'd1);
    check_eq("quo_hold", 16'(bus.quotient), 16'd15);
    drive_go(4'd15, 4'd1, 1'b0); wait_done(1'b0);
    drive_go(4'd3, 4'd7, 1'b0);  wait_done(1'b0);

    // go held high: second operation may only start once the first has returned to IDLE.
    @(posedge clk); #1;
    bus.go = 1'b1; bus.dividend = 4'd9; bus.divisor = 4'd2;
    exp_q.push_back(model(4'd9, 4'd2));
    exp_q.push_back(model(4'd9, 4'd2));
    prev_cs = 0; starts = 0; t = 0; first_t = 0; second_t = 0;
    while (starts < 2 && t < 40) begin
      @(negedge clk);
      t++;
      if (bus.CS == 2'd1 && prev_cs == 0) begin
        starts++;
        if (starts == 1) first_t = t;
        else second_t = t;
      end
      prev_cs = int'(bus.CS);
    end
    bus.go = 1'b0;
    check_eq("hold_go_spacing", 16'(second_t - first_t), 16'(W + 2));
    repeat (8) @(negedge clk);
    check_eq("hold_go_drained", 16'(exp_q.size()), 16'd0);

    // Reset in the middle of an operation: no done, outputs cleared.
    @(posedge clk); #1;
    bus.go = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd3;
    @(posedge clk); #1;
    bus.go = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    last_q = '0;
    last_r = '0;
    @(negedge clk);
    check_eq("midrst_cs", 16'(bus.CS), 16'd0);
    check_eq("midrst_busy", 16'(bus.busy), 16'd0);
    check_eq("midrst_quo", 16'(bus.quotient), 16'd0);
    check_eq("midrst_rem", 16'(bus.remainder), 16'd0);
    check_eq("midrst_done", 16'(bus.done), 16'd0);
    repeat (6) @(negedge clk);
    drive_go(4'd14, 4'd3, 1'b0); wait_done(1'b0);

    // Operands forced to 0/0 right after acceptance must not disturb the result.
    drive_go(4'd9, 4'd2, 1'b1);  wait_done(1'b0);
    drive_go(4'd0, 4'd5, 1'b0);  wait_done(1'b0);

    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      drive_go(ra, rb, 1'b0);
      wait_done(rb == '0);
    end

    repeat (2) @(negedge clk);
    check_eq("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
